// File: rtl/dpath_bus_arbiter.sv
// Round-robin arbiter for one shared datapath bus with four requesters.
// Grants one owner at a time, bounds hold time under contention, and inserts a turnaround cycle between owners.
module dpath_bus_arbiter #(
    parameter int N        = 32,
    parameter int MAX_HOLD = 8,
    parameter int d_Y      = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   REQ,
    input  logic [N-1:0] IN0,
    input  logic [N-1:0] IN1,
    input  logic [N-1:0] IN2,
    input  logic [N-1:0] IN3,
    output logic [3:0]   GNT,
    output logic [1:0]   OWNER,
    output logic         BUS_EN,
    output logic [N-1:0] Y,
    output logic         Y_VALID,
    output logic         BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    // Output delay is simulation-only; nothing in the logic depends on it.
    logic unused_dy;
    assign unused_dy = (d_Y != 0);

    state_t       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   o_q, o_d;
    logic [7:0]   hcnt_q, hcnt_d;
    logic [3:0]   gnt_d;
    logic [1:0]   owner_d;
    logic [N-1:0] y_d;
    logic         y_valid_d;

    logic [N-1:0] in_sel;
    logic         found;
    logic [1:0]   pick;
    logic [1:0]   idx;
    logic         others;
    logic         release_own;

    always_comb begin
        case (o_q)
            2'd0:    in_sel = IN0;
            2'd1:    in_sel = IN1;
            2'd2:    in_sel = IN2;
            default: in_sel = IN3;
        endcase
    end

    // Scan from the far end back toward ptr so the closest requester wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (REQ[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign others      = |(REQ & ~(4'b0001 << o_q));
    assign release_own = !REQ[o_q] || ((hcnt_q == HOLD_MAX) && others);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        o_d       = o_q;
        hcnt_d    = hcnt_q;
        gnt_d     = GNT;
        owner_d   = OWNER;
        y_d       = Y;
        y_valid_d = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (found) begin
                    state_d = OWN;
                    o_d     = pick;
                    owner_d = pick;
                    gnt_d   = 4'b0001 << pick;
                    hcnt_d  = 8'd1;
                end else begin
                    state_d = IDLE;
                    owner_d = 2'd0;
                    gnt_d   = 4'b0000;
                end
            end
            OWN: begin
                y_valid_d = REQ[o_q];
                if (REQ[o_q]) begin
                    y_d = in_sel;
                end
                if (release_own) begin
                    state_d = TURN;
                    gnt_d   = 4'b0000;
                    owner_d = 2'd0;
                    ptr_d   = o_q + 2'd1;
                end else if (hcnt_q != HOLD_MAX) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = 2'd0;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            o_q     <= 2'd0;
            hcnt_q  <= 8'd0;
            GNT     <= 4'b0000;
            OWNER   <= 2'd0;
            BUS_EN  <= 1'b0;
            Y       <= '0;
            Y_VALID <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            o_q     <= o_d;
            hcnt_q  <= hcnt_d;
            GNT     <= gnt_d;
            OWNER   <= owner_d;
            BUS_EN  <= |gnt_d;
            Y       <= y_d;
            Y_VALID <= y_valid_d;
            BUSY    <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_dpath_bus_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, and random traffic against an ownership model.
module tb_dpath_bus_arbiter;

    localparam int MAXH = 8;

    logic        CLK;
    logic        RESET;
    logic [3:0]  REQ;
    logic [3:0]  REQ_B;
    logic [31:0] IN0, IN1, IN2, IN3;
    logic [3:0]  GNT, B_GNT;
    logic [1:0]  OWNER, B_OWNER;
    logic        BUS_EN, B_BUS_EN;
    logic [31:0] Y, B_Y;
    logic        Y_VALID, B_Y_VALID;
    logic        BUSY, B_BUSY;

    int total = 0;
    int bad   = 0;

    dpath_bus_arbiter #(.N(32), .MAX_HOLD(MAXH), .d_Y(1)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ),
        .IN0(IN0), .IN1(IN1), .IN2(IN2), .IN3(IN3),
        .GNT(GNT), .OWNER(OWNER), .BUS_EN(BUS_EN),
        .Y(Y), .Y_VALID(Y_VALID), .BUSY(BUSY)
    );

    dpath_bus_arbiter #(.N(32), .MAX_HOLD(1), .d_Y(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .REQ(REQ_B),
        .IN0(IN0), .IN1(IN1), .IN2(IN2), .IN3(IN3),
        .GNT(B_GNT), .OWNER(B_OWNER), .BUS_EN(B_BUS_EN),
        .Y(B_Y), .Y_VALID(B_Y_VALID), .BUSY(B_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: who owns the bus, how many cycles it has held it, and whether a gap cycle is in progress.
    int          m_owner = -1;
    bit          m_gap   = 1'b0;
    int          m_held  = 0;
    int          m_ptr   = 0;
    logic [31:0] m_y     = '0;
    bit          m_yv    = 1'b0;

    function automatic logic [31:0] in_of(input int i);
        case (i)
            0:       return IN0;
            1:       return IN1;
            2:       return IN2;
            default: return IN3;
        endcase
    endfunction

    task automatic model_edge();
        bit comp;
        if (RESET) begin
            m_owner = -1; m_gap = 0; m_held = 0; m_ptr = 0; m_y = '0; m_yv = 0;
        end else if (m_owner >= 0) begin
            m_yv = REQ[m_owner];
            if (REQ[m_owner]) m_y = in_of(m_owner);
            m_held++;
            comp = 1'b0;
            for (int j = 0; j < 4; j++) if (j != m_owner && REQ[j]) comp = 1'b1;
            if (!REQ[m_owner] || (m_held >= MAXH && comp)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else begin
            m_yv  = 1'b0;
            m_gap = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (REQ[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_held  = 0;
                    break;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input logic [3:0] req);
        logic [3:0] eg;
        RESET = rst;
        REQ   = req;
        @(posedge CLK);
        model_edge();
        #1;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        chk("gnt",     32'(GNT),     32'(eg));
        chk("owner",   32'(OWNER),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("bus_en",  32'(BUS_EN),  32'(m_owner >= 0));
        chk("y",       Y,            m_y);
        chk("y_valid", 32'(Y_VALID), 32'(m_yv));
        chk("busy",    32'(BUSY),    32'((m_owner >= 0) || m_gap));
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [31:0] in0;
        logic [3:0]  gnt;
        logic [31:0] y;
        bit          yv;
        bit          busy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int order[$];
        int runs[$];
        int run;
        int exp_order[5];
        logic [3:0] exp_b[8];

        tbl[0] = '{1'b1, 4'b0000, 32'h00, 4'b0000, 32'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'b0001, 32'h00, 4'b0001, 32'h00, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 4'b0001, 32'h11, 4'b0001, 32'h11, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 4'b0001, 32'h22, 4'b0001, 32'h22, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 4'b0001, 32'h33, 4'b0001, 32'h33, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 4'b0001, 32'h44, 4'b0001, 32'h44, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 4'b0001, 32'h55, 4'b0001, 32'h55, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 4'b0000, 32'h66, 4'b0000, 32'h55, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 4'b0000, 32'h77, 4'b0000, 32'h55, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 4'b0000, 32'h88, 4'b0000, 32'h55, 1'b0, 1'b0};

        RESET = 1'b1; REQ = '0; REQ_B = '0;
        IN0 = '0; IN1 = '0; IN2 = '0; IN3 = '0;
        @(posedge CLK); #1;

        // single requester vectors
        for (int i = 0; i < 10; i++) begin
            IN0 = tbl[i].in0;
            step(tbl[i].rst, tbl[i].req);
            chk("tbl_gnt",  32'(GNT),     32'(tbl[i].gnt));
            chk("tbl_y",    Y,            tbl[i].y);
            chk("tbl_yv",   32'(Y_VALID), 32'(tbl[i].yv));
            chk("tbl_busy", 32'(BUSY),    32'(tbl[i].busy));
        end

        IN0 = 32'hA0; IN1 = 32'hA1; IN2 = 32'hA2; IN3 = 32'hA3;

        // all four requesting: round-robin order with full holds
        exp_order = '{0, 1, 2, 3, 0};
        step(1'b1, 4'b0000);
        run = 0;
        for (int i = 0; i < 45; i++) begin
            step(1'b0, 4'b1111);
            if (GNT != 4'b0000) begin
                if (run == 0) order.push_back(int'(OWNER));
                run++;
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
        chk("rr_grants", 32'(order.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
        for (int i = 0; i < 4; i++)
            if (i < runs.size()) chk("rr_hold", 32'(runs[i]), 32'(MAXH));

        // voluntary release by owner 2 while 0 waits
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        chk("vol_g1", 32'(GNT), 32'h4);
        step(1'b0, 4'b0101);
        chk("vol_g2", 32'(GNT), 32'h4);
        step(1'b0, 4'b0101);
        chk("vol_g3", 32'(GNT), 32'h4);
        step(1'b0, 4'b0001);
        chk("vol_turn", 32'(GNT), 32'h0);
        step(1'b0, 4'b0001);
        chk("vol_next", 32'(GNT), 32'h1);

        // hold saturation, then a competitor forces release
        step(1'b1, 4'b0000);
        for (int i = 0; i < 21; i++) begin
            step(1'b0, 4'b0010);
            chk("sat_hold", 32'(GNT), 32'h2);
        end
        step(1'b0, 4'b1010);
        chk("sat_drop", 32'(GNT), 32'h0);
        step(1'b0, 4'b1010);
        chk("sat_next", 32'(GNT), 32'h8);

        // reset while requester 1 owns the bus
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        step(1'b1, 4'b0110);
        chk("rst_gnt",   32'(GNT),     32'h0);
        chk("rst_owner", 32'(OWNER),   32'h0);
        chk("rst_en",    32'(BUS_EN),  32'h0);
        chk("rst_y",     Y,            32'h0);
        chk("rst_yv",    32'(Y_VALID), 32'h0);
        chk("rst_busy",  32'(BUSY),    32'h0);
        step(1'b0, 4'b0110);
        chk("rst_regrant", 32'(GNT),   32'h2);
        chk("rst_owner1",  32'(OWNER), 32'h1);

        // MAX_HOLD=1 instance: one-cycle grants alternating with turnaround
        exp_b = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        REQ_B = 4'b0011;
        step(1'b1, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0000);
            chk("mh1_gnt", 32'(B_GNT), 32'(exp_b[i]));
        end
        REQ_B = 4'b0000;

        // random traffic with sticky requests and occasional resets
        step(1'b1, 4'b0000);
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] r;
            r = REQ;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            IN0 = $urandom; IN1 = $urandom; IN2 = $urandom; IN3 = $urandom;
            step($urandom_range(0, 199) == 0, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
